// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round-step functions.
// Byte i of a state/key occupies bits [8i+7:8i]; byte 4c+r is row r of column c.
package aes_pkg;

    typedef logic [127:0] aesState_t;
    typedef logic [7:0]   aesByte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } engState_t;

    localparam int NB        = 4;
    localparam int NK        = 4;
    localparam int NR_AES128 = 10;

    localparam aesByte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic aesByte_t xtime(input aesByte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aesState_t sub_bytes(input aesState_t s);
        aesState_t res;
        for (int i = 0; i < 4 * NB; i++) begin
            res[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return res;
    endfunction

    // Row r rotates left by r columns: new (r,c) takes old (r,(c+r) mod 4).
    function automatic aesState_t shift_rows(input aesState_t s);
        aesState_t res;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c+r) +: 8] = s[8*(4*((c+r)%NB)+r) +: 8];
            end
        end
        return res;
    endfunction

    function automatic aesState_t mix_columns(input aesState_t s);
        aesState_t res;
        aesByte_t  a0, a1, a2, a3;
        for (int c = 0; c < NB; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            res[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rkey,
    input  logic         last,
    output logic [127:0] nextState
);

    aesState_t shifted;

    always_comb begin
        shifted   = shift_rows(sub_bytes(state));
        nextState = (last ? shifted : mix_columns(shifted)) ^ rkey;
    end

endmodule

// File: rtl/aes_enc_round_engine.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
// Round keys come straight from the key-expansion stage and must stay stable per block.
module aes_enc_round_engine
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] rkey0,
    input  logic [127:0] rkey1,
    input  logic [127:0] rkey2,
    input  logic [127:0] rkey3,
    input  logic [127:0] rkey4,
    input  logic [127:0] rkey5,
    input  logic [127:0] rkey6,
    input  logic [127:0] rkey7,
    input  logic [127:0] rkey8,
    input  logic [127:0] rkey9,
    input  logic [127:0] rkey10,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (NR != NR_AES128 || NK != 4) begin : gNrCheck
        $error("aes_enc_round_engine supports only AES-128 (NR=10)");
    end
    if ((1 << CNT_W) <= NR) begin : gCntCheck
        $error("aes_enc_round_engine: CNT_W too narrow for NR");
    end

    engState_t        engState;
    logic [CNT_W-1:0] roundCnt;
    aesState_t        aesState;
    aesState_t        nextState;
    logic [127:0]     roundKey;
    logic             lastRound;

    assign lastRound = (roundCnt == CNT_W'(NR));
    assign out_data  = aesState;

    always_comb begin
        roundKey = '0;
        case (roundCnt)
            CNT_W'(1):  roundKey = rkey1;
            CNT_W'(2):  roundKey = rkey2;
            CNT_W'(3):  roundKey = rkey3;
            CNT_W'(4):  roundKey = rkey4;
            CNT_W'(5):  roundKey = rkey5;
            CNT_W'(6):  roundKey = rkey6;
            CNT_W'(7):  roundKey = rkey7;
            CNT_W'(8):  roundKey = rkey8;
            CNT_W'(9):  roundKey = rkey9;
            CNT_W'(10): roundKey = rkey10;
            default:    roundKey = '0;
        endcase
    end

    aes_enc_round uRound (
        .state     (aesState),
        .rkey      (roundKey),
        .last      (lastRound),
        .nextState (nextState)
    );

    // Handshake outputs are registered alongside the state so they switch with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            engState  <= ST_IDLE;
            roundCnt  <= '0;
            aesState  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (engState)
                ST_IDLE: begin
                    if (in_valid) begin
                        aesState <= in_data ^ rkey0;
                        roundCnt <= CNT_W'(1);
                        engState <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    aesState <= nextState;
                    roundCnt <= roundCnt + CNT_W'(1);
                    if (lastRound) begin
                        engState  <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        engState  <= ST_IDLE;
                        roundCnt  <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    engState <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
